fountain_droplet_framer: RTL and testbench

Downstream stage of `fountain_v1_basic`. Accepts each 64-bit encoded droplet with its 16-bit generator seed, buffers it in a small FIFO, and emits a three-word frame over a valid/ready stream: header, payload, checksum. Absorbs the bursty, non-backpressured droplet output of the encoder and gives the link/transport layer a self-delimiting frame stream.

---
 rtl/fountain_pkg.sv | 35 +++
 rtl/fountain_sync_fifo.sv | 53 +++++
 rtl/fountain_droplet_framer.sv | 131 +++++++++++++
 tb/tb_fountain_droplet_framer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fountain_pkg.sv
// Shared constants, FSM state type and header builder for the fountain droplet framer.
package fountain_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hF0A5;
  localparam int unsigned SEQ_W     = 16;
  localparam int unsigned HDR_W     = 64;

  localparam int unsigned HDR_SYNC_LSB = 48;
  localparam int unsigned HDR_SEQ_LSB  = 32;
  localparam int unsigned HDR_SEED_LSB = 16;
  localparam int unsigned HDR_LEN_LSB  = 0;

  localparam logic [15:0] FRAME_LEN = 16'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_CHK
  } frame_state_t;

  // Header word: sync | sequence | seed | frame length in words.
  function automatic logic [HDR_W-1:0] make_header(input logic [15:0] sync,
                                                   input logic [15:0] seq,
                                                   input logic [15:0] seed);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 16] = sync;
    h[HDR_SEQ_LSB  +: 16] = seq;
    h[HDR_SEED_LSB +: 16] = seed;
    h[HDR_LEN_LSB  +: 16] = FRAME_LEN;
    return h;
  endfunction

endpackage

// File: rtl/fountain_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and a peek at the entry behind the head.
module fountain_sync_fifo #(
  parameter int unsigned WIDTH  = 80,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PEEK_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [PEEK_W-1:0]        rd_peek,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;

  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  // Upper bits of the second entry, needed to build the next header without a bubble.
  assign rd_peek = mem[rd_ptr + AW'(1)][WIDTH-1 -: PEEK_W];

endmodule

// File: rtl/fountain_droplet_framer.sv
// Buffers encoded droplets and emits header/payload/checksum frames on a valid/ready stream.
module fountain_droplet_framer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SEED_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] SYNC_WORD  = fountain_pkg::SYNC_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEED_W-1:0] in_seed,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic [15:0]       frame_count,
  output logic              overflow
);

  localparam int unsigned ENTRY_W = DATA_W + SEED_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  fountain_pkg::frame_state_t state;

  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [SEED_W-1:0]  peek_seed;
  logic [CNT_W-1:0]   fifo_count;
  logic [15:0]        seq;

  logic [DATA_W-1:0]  head_data;
  logic [SEED_W-1:0]  head_seed;
  logic [SEED_W-1:0]  next_seed;
  logic               more_after_pop;
  logic [DATA_W-1:0]  hdr_head;
  logic [DATA_W-1:0]  hdr_next;

  fountain_sync_fifo #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (FIFO_DEPTH),
    .PEEK_W (SEED_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({in_seed, in_data}),
    .pop     (pop),
    .rd_data (head),
    .rd_peek (peek_seed),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready    = ~fifo_full;
  assign push        = in_valid & in_ready;
  assign pop         = (state == fountain_pkg::ST_CHK) & out_ready;
  assign frame_count = seq;

  assign head_data = head[DATA_W-1:0];
  assign head_seed = head[ENTRY_W-1 -: SEED_W];

  // Next frame source after a checksum pop: second FIFO entry, or the droplet arriving now.
  assign more_after_pop = (fifo_count > CNT_W'(1)) | push;
  assign next_seed      = (fifo_count > CNT_W'(1)) ? peek_seed : in_seed;

  assign hdr_head = DATA_W'(fountain_pkg::make_header(SYNC_WORD, seq, 16'(head_seed)));
  assign hdr_next = DATA_W'(fountain_pkg::make_header(SYNC_WORD, seq + 16'd1, 16'(next_seed)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= fountain_pkg::ST_IDLE;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
      seq       <= '0;
      overflow  <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;

      case (state)
        fountain_pkg::ST_IDLE: begin
          if (!fifo_empty) begin
            state     <= fountain_pkg::ST_HDR;
            out_valid <= 1'b1;
            out_sof   <= 1'b1;
            out_data  <= hdr_head;
          end
        end
        fountain_pkg::ST_HDR: begin
          if (out_ready) begin
            state    <= fountain_pkg::ST_PAY;
            out_sof  <= 1'b0;
            out_data <= head_data;
          end
        end
        fountain_pkg::ST_PAY: begin
          if (out_ready) begin
            state    <= fountain_pkg::ST_CHK;
            out_eof  <= 1'b1;
            out_data <= hdr_head ^ head_data;
          end
        end
        fountain_pkg::ST_CHK: begin
          if (out_ready) begin
            seq     <= seq + 16'd1;
            out_eof <= 1'b0;
            if (more_after_pop) begin
              state    <= fountain_pkg::ST_HDR;
              out_sof  <= 1'b1;
              out_data <= hdr_next;
            end else begin
              state     <= fountain_pkg::ST_IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
            end
          end
        end
        default: state <= fountain_pkg::ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fountain_droplet_framer.sv
// Scoreboard bench for fountain_droplet_framer: expected frame words queued at droplet push.
module tb_fountain_droplet_framer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] data;
    logic        sof;
    logic        eof;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic [15:0] in_seed;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sof;
  logic        out_eof;
  logic [15:0] frame_count;
  logic        overflow;

  fountain_droplet_framer #(
    .DATA_W     (64),
    .SEED_W     (16),
    .FIFO_DEPTH (DEPTH),
    .SYNC_WORD  (16'hF0A5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_seed     (in_seed),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .frame_count (frame_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  word_t       exp_q[$];
  int          model_cnt;
  logic [15:0] push_seq;
  logic [15:0] model_seq;
  logic        model_ovf;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [63:0] ref_hdr(input logic [15:0] seq, input logic [15:0] seed);
    return {16'hF0A5, seq, seed, 16'h0003};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    model_cnt = 0;
    push_seq  = '0;
    model_seq = '0;
    model_ovf = 1'b0;
  endtask

  // One cycle: drive inputs at the falling edge, update the model, advance to the next falling edge.
  task automatic tick(input logic v, input logic [63:0] d, input logic [15:0] s, input logic r,
                      output logic acc, output word_t ow, output word_t ew);
    logic full_m;
    logic [63:0] h;
    in_valid  = v;
    in_data   = d;
    in_seed   = s;
    out_ready = r;
    full_m = (model_cnt == DEPTH);
    acc = out_valid && r;
    ow  = '{data: out_data, sof: out_sof, eof: out_eof};
    ew  = '{data: '0, sof: 1'b1, eof: 1'b1};
    if (acc && exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      if (ew.eof) begin
        model_cnt--;
        model_seq++;
      end
    end
    if (v) begin
      if (!full_m) begin
        h = ref_hdr(push_seq, s);
        exp_q.push_back('{data: h,     sof: 1'b1, eof: 1'b0});
        exp_q.push_back('{data: d,     sof: 1'b0, eof: 1'b0});
        exp_q.push_back('{data: h ^ d, sof: 1'b0, eof: 1'b1});
        model_cnt++;
        push_seq++;
      end else begin
        model_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_seed = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_sof, out_eof, overflow, in_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_flags: got v/sof/eof/ovf/rdy=%b want 00001",
               {out_valid, out_sof, out_eof, overflow, in_ready});
    end
    n_cmp++;
    if (out_data !== 64'h0) begin
      n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    n_cmp++;
    if (frame_count !== 16'h0) begin
      n_bad++; $display("FAIL reset_frame_count: got %h want 0", frame_count);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_single();
    logic acc; word_t o; word_t e; int n_acc; int t_first;
    n_acc = 0; t_first = -1;
    tick(1'b1, 64'h0123_4567_89AB_CDEF, 16'h00A1, 1'b1, acc, o, e);
    for (int c = 1; c < 12 && exp_q.size() > 0; c++) begin
      tick(1'b0, '0, '0, 1'b1, acc, o, e);
      if (acc) begin
        n_cmp++;
        if (o !== e) begin
          n_bad++; $display("FAIL single_word%0d: got %h/%b/%b want %h/%b/%b",
                            n_acc, o.data, o.sof, o.eof, e.data, e.sof, e.eof);
        end
        if (n_acc == 0) begin
          t_first = c;
          n_cmp++;
          if (o.data !== 64'hF0A5_0000_00A1_0003) begin
            n_bad++; $display("FAIL single_hdr_const: got %h want F0A5000000A10003", o.data);
          end
        end
        if (n_acc == 2) begin
          n_cmp++;
          if (o.data !== 64'hF186_4567_890A_CDEC) begin
            n_bad++; $display("FAIL single_chk_const: got %h want F1864567890ACDEC", o.data);
          end
        end
        n_acc++;
      end
    end
    n_cmp++;
    if (t_first != 2 || n_acc != 3) begin
      n_bad++; $display("FAIL single_latency: first accept cycle %0d, accepts %0d; want 2, 3",
                        t_first, n_acc);
    end
    n_cmp++;
    if (frame_count !== model_seq) begin
      n_bad++; $display("FAIL single_frame_count: got %0d want %0d", frame_count, model_seq);
    end
  endtask

  task automatic test_backpressure();
    logic acc; word_t o; word_t e; word_t prev; logic vld; logic stalled; int n_acc;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n_acc = 0; stalled = 1'b0; prev = '0;
    vld = out_valid;
    tick(1'b1, 64'hDEAD_BEEF_0000_1111, 16'h5A5A, pat[0], acc, o, e);
    for (int c = 1; c < 30 && exp_q.size() > 0; c++) begin
      vld = out_valid;
      tick(1'b0, '0, '0, pat[c % 4], acc, o, e);
      if (stalled) begin
        n_cmp++;
        if (o !== prev) begin
          n_bad++; $display("FAIL bp_hold: got %h/%b/%b want %h/%b/%b",
                            o.data, o.sof, o.eof, prev.data, prev.sof, prev.eof);
        end
      end
      if (acc) begin
        n_acc++;
        n_cmp++;
        if (o !== e) begin
          n_bad++; $display("FAIL bp_word: got %h/%b/%b want %h/%b/%b",
                            o.data, o.sof, o.eof, e.data, e.sof, e.eof);
        end
      end
      stalled = vld && !pat[c % 4];
      prev = o;
    end
    n_cmp++;
    if (n_acc != 3) begin
      n_bad++; $display("FAIL bp_accepts: got %0d want 3", n_acc);
    end
    n_cmp++;
    if (frame_count !== model_seq) begin
      n_bad++; $display("FAIL bp_frame_count: got %0d want %0d", frame_count, model_seq);
    end
  endtask

  task automatic test_burst();
    logic acc; word_t o; word_t e; int n_acc; int t_first; int t_last;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++)
      tick(1'b1, 64'hB000_0000_0000_0000 + 64'(i), 16'h0B00 + 16'(i), 1'b0, acc, o, e);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++; $display("FAIL burst_overflow: got %b want 1", overflow);
    end
    n_cmp++;
    if (in_ready !== (model_cnt != DEPTH)) begin
      n_bad++; $display("FAIL burst_in_ready: got %b want %b", in_ready, model_cnt != DEPTH);
    end
    n_acc = 0; t_first = -1; t_last = -1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      tick(1'b0, '0, '0, 1'b1, acc, o, e);
      if (acc) begin
        if (t_first < 0) t_first = c;
        t_last = c;
        n_acc++;
        n_cmp++;
        if (o !== e) begin
          n_bad++; $display("FAIL burst_word%0d: got %h/%b/%b want %h/%b/%b",
                            n_acc, o.data, o.sof, o.eof, e.data, e.sof, e.eof);
        end
      end
    end
    n_cmp++;
    if (n_acc != 12 || (t_last - t_first) != 11) begin
      n_bad++; $display("FAIL burst_b2b: accepts %0d over %0d cycles; want 12 over 12",
                        n_acc, t_last - t_first + 1);
    end
    n_cmp++;
    if (frame_count !== 16'd4) begin
      n_bad++; $display("FAIL burst_frame_count: got %0d want 4", frame_count);
    end
  endtask

  task automatic test_simul_push_pop();
    logic acc; word_t o; word_t e; logic pushed; logic v;
    pushed = 1'b0;
    tick(1'b1, 64'hA1A1_A1A1_A1A1_A1A1, 16'h1111, 1'b0, acc, o, e);
    tick(1'b1, 64'hB2B2_B2B2_B2B2_B2B2, 16'h2222, 1'b0, acc, o, e);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      v = !pushed && out_valid && exp_q.size() > 0 && exp_q[0].eof;
      tick(v, 64'hC3C3_C3C3_C3C3_C3C3, 16'h3333, 1'b1, acc, o, e);
      if (acc) begin
        n_cmp++;
        if (o !== e) begin
          n_bad++; $display("FAIL simul_word: got %h/%b/%b want %h/%b/%b",
                            o.data, o.sof, o.eof, e.data, e.sof, e.eof);
        end
      end
      if (v) begin
        pushed = 1'b1;
        n_cmp++;
        if (dut.u_fifo.count !== 3'd2) begin
          n_bad++; $display("FAIL simul_occupancy: got %0d want 2", dut.u_fifo.count);
        end
      end
    end
    n_cmp++;
    if (!pushed || exp_q.size() != 0) begin
      n_bad++; $display("FAIL simul_drain: pushed %b, %0d words outstanding; want 1, 0",
                        pushed, exp_q.size());
    end
  endtask

  task automatic test_seq_wrap();
    logic acc; word_t o; word_t e; int n_hdr; logic [15:0] seen [2];
    n_hdr = 0; seen[0] = 16'h1234; seen[1] = 16'h1234;
    force dut.seq = 16'hFFFF;
    @(posedge clk); #1;
    release dut.seq;
    @(negedge clk);
    push_seq = 16'hFFFF; model_seq = 16'hFFFF;
    tick(1'b1, 64'h1111_2222_3333_4444, 16'hAAAA, 1'b1, acc, o, e);
    tick(1'b1, 64'h5555_6666_7777_8888, 16'hBBBB, 1'b1, acc, o, e);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick(1'b0, '0, '0, 1'b1, acc, o, e);
      if (acc) begin
        if (o.sof && n_hdr < 2) begin
          seen[n_hdr] = o.data[47:32];
          n_hdr++;
        end
        n_cmp++;
        if (o !== e) begin
          n_bad++; $display("FAIL wrap_word: got %h/%b/%b want %h/%b/%b",
                            o.data, o.sof, o.eof, e.data, e.sof, e.eof);
        end
      end
    end
    n_cmp++;
    if (seen[0] !== 16'hFFFF || seen[1] !== 16'h0000) begin
      n_bad++; $display("FAIL wrap_seq: got %h,%h want FFFF,0000", seen[0], seen[1]);
    end
    n_cmp++;
    if (frame_count !== 16'h0001) begin
      n_bad++; $display("FAIL wrap_frame_count: got %h want 0001", frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic acc; word_t o; word_t e; int eof_seen; int n_acc;
    tick(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 16'h7777, 1'b1, acc, o, e);
    tick(1'b0, '0, '0, 1'b1, acc, o, e);
    tick(1'b0, '0, '0, 1'b1, acc, o, e);
    n_cmp++;
    if (!acc || o !== e) begin
      n_bad++; $display("FAIL rstmid_hdr: accepted %b got %h want %h", acc, o.data, e.data);
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01 || frame_count !== 16'h0) begin
      n_bad++; $display("FAIL rstmid_after: got valid/rdy=%b count=%0d want 01, 0",
                        {out_valid, in_ready}, frame_count);
    end
    eof_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, '0, '0, 1'b1, acc, o, e);
      if (acc) eof_seen++;
    end
    n_cmp++;
    if (eof_seen != 0) begin
      n_bad++; $display("FAIL rstmid_no_words: got %0d words want 0", eof_seen);
    end
    n_acc = 0;
    tick(1'b1, 64'h9999_8888_7777_6666, 16'h4242, 1'b1, acc, o, e);
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      tick(1'b0, '0, '0, 1'b1, acc, o, e);
      if (acc) begin
        if (n_acc == 0) begin
          n_cmp++;
          if (o.data[47:32] !== 16'h0000) begin
            n_bad++; $display("FAIL rstmid_seq0: got %h want 0000", o.data[47:32]);
          end
        end
        n_acc++;
        n_cmp++;
        if (o !== e) begin
          n_bad++; $display("FAIL rstmid_word: got %h/%b/%b want %h/%b/%b",
                            o.data, o.sof, o.eof, e.data, e.sof, e.eof);
        end
      end
    end
    n_cmp++;
    if (n_acc != 3) begin
      n_bad++; $display("FAIL rstmid_accepts: got %0d want 3", n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_burst();
    test_simul_push_pop();
    test_seq_wrap();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
